// File: rtl/mul_ex_stage.sv
// mul_ex_stage
//   Execute-stage wrapper around the 8-bit signed multiplier (op4).
//   S1 registers decode-issued operands and feeds the multiplier; S2 captures
//   the truncated product for writeback. Two-deep valid/ready pipeline with
//   backpressure, synchronous flush and a wrapping retired-operation counter.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     flush                synchronous kill of both stages
//     in_valid/in_ready    operand handshake from decode
//     op_a, op_b, in_rd    operands (low 8 bits used, signed), dest index
//     out_valid/out_ready  result handshake to writeback
//     result, out_rd       {zeros, product[7:0]}, dest index
//     retired              results handed to writeback, wraps
//     res_zero             (MUL_EX_ZERO_FLAG_EN only) product[7:0] == 0
//
//   Build option: define MUL_EX_ZERO_FLAG_EN to add the res_zero output.

module mul_ex_stage #(
  parameter int DW   = 12,
  parameter int RDW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   op_a,
  input  logic [DW-1:0]   op_b,
  input  logic [RDW-1:0]  in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   result,
  output logic [RDW-1:0]  out_rd,
  output logic [CNTW-1:0] retired
`ifdef MUL_EX_ZERO_FLAG_EN
  ,
  output logic            res_zero
`endif
);

  logic            s1_valid_q, s1_valid_d;
  logic [7:0]      s1_a_q, s1_a_d;
  logic [7:0]      s1_b_q, s1_b_d;
  logic [RDW-1:0]  s1_rd_q, s1_rd_d;
  logic            s2_valid_q, s2_valid_d;
  logic [7:0]      s2_res_q, s2_res_d;
  logic [RDW-1:0]  s2_rd_q, s2_rd_d;
  logic [CNTW-1:0] retired_q, retired_d;
`ifdef MUL_EX_ZERO_FLAG_EN
  logic            s2_zero_q, s2_zero_d;
`endif

  logic s1_adv, s2_adv, accept, handoff;
  logic signed [15:0] prod_full;
  logic [7:0] mul_lo;

  // Operand high bits and product high bits are architecturally discarded.
  logic unused_hi;
  assign unused_hi = ^{op_a[DW-1:8], op_b[DW-1:8], prod_full[15:8]};

  // op4: low byte of the signed 8x8 product.
  assign prod_full = $signed(s1_a_q) * $signed(s1_b_q);
  assign mul_lo    = prod_full[7:0];

  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  // rst_n in the path keeps in_ready low for the whole reset assertion.
  assign in_ready = s1_adv & !flush & rst_n;
  assign accept   = in_valid & in_ready;
  assign handoff  = s2_valid_q & out_ready & !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_rd_d    = s2_rd_q;
    retired_d  = retired_q;
`ifdef MUL_EX_ZERO_FLAG_EN
    s2_zero_d  = s2_zero_q;
`endif

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = op_a[7:0];
      s1_b_d     = op_b[7:0];
      s1_rd_d    = in_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      // Data only moves with a real operation so bubbles leave S2 untouched.
      if (s1_valid_q) begin
        s2_res_d  = mul_lo;
        s2_rd_d   = s1_rd_q;
`ifdef MUL_EX_ZERO_FLAG_EN
        s2_zero_d = (mul_lo == 8'h00);
`endif
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    if (handoff) begin
      retired_d = retired_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_rd_q    <= '0;
      retired_q  <= '0;
`ifdef MUL_EX_ZERO_FLAG_EN
      s2_zero_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_rd_q    <= s2_rd_d;
      retired_q  <= retired_d;
`ifdef MUL_EX_ZERO_FLAG_EN
      s2_zero_q  <= s2_zero_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = {{(DW-8){1'b0}}, s2_res_q};
  assign out_rd    = s2_rd_q;
  assign retired   = retired_q;
`ifdef MUL_EX_ZERO_FLAG_EN
  assign res_zero  = s2_zero_q;
`endif

endmodule

// File: tb/tb_mul_ex_stage.sv
module tb_mul_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] op_a;
  logic [11:0] op_b;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic [2:0]  out_rd;
  logic [15:0] retired;
`ifdef MUL_EX_ZERO_FLAG_EN
  logic        res_zero;
`endif

  int total;
  int bad;

  mul_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_rd    (out_rd),
    .retired   (retired)
`ifdef MUL_EX_ZERO_FLAG_EN
    ,
    .res_zero  (res_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    op_a      = 12'h003;
    op_b      = 12'h005;
    in_rd     = 3'd1;
    out_ready = 1'b1;
    #2;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 12'h000) begin bad++; $display("FAIL reset_result: got %h want 000", result); end
    total++; if (out_rd !== 3'd0) begin bad++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid: got %b want 0", out_valid); end
    do_reset();
  endtask

  task automatic test_single_op();
    in_valid = 1'b1; op_a = 12'h003; op_b = 12'h005; in_rd = 3'd2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    total++; if (result !== 12'h00F) begin bad++; $display("FAIL single_result: got %h want 00F", result); end
    total++; if (out_rd !== 3'd2) begin bad++; $display("FAIL single_rd: got %0d want 2", out_rd); end
    @(posedge clk); #1;
    total++; if (retired !== 16'd1) begin bad++; $display("FAIL single_retired: got %0d want 1", retired); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_bubble: got %b want 0", out_valid); end
  endtask

  // Signed/wrap vectors issued back-to-back; results one per cycle in order.
  task automatic test_signed_back_to_back();
    logic [11:0] va [5] = '{12'h0FF, 12'h007, 12'h080, 12'hA7F, 12'h010};
    logic [11:0] vb [5] = '{12'h0FF, 12'h0FD, 12'h080, 12'h37F, 12'h010};
    logic [11:0] ve [5] = '{12'h001, 12'h0EB, 12'h000, 12'h001, 12'h000};
    for (int c = 0; c <= 5; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; op_a = va[c]; op_b = vb[c]; in_rd = 3'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL signed_valid[%0d]: got %b want 1", c - 1, out_valid); end
        total++; if (result !== ve[c-1]) begin bad++; $display("FAIL signed_result[%0d]: got %h want %h", c - 1, result, ve[c-1]); end
        total++; if (out_rd !== 3'(c)) begin bad++; $display("FAIL signed_rd[%0d]: got %0d want %0d", c - 1, out_rd, c); end
      end
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL signed_bubble: got %b want 0", out_valid); end
    total++; if (retired !== 16'd6) begin bad++; $display("FAIL signed_retired: got %0d want 6", retired); end
  endtask

  task automatic test_backpressure();
    logic [11:0] ea [4] = '{12'h001, 12'h003, 12'h005, 12'h007};
    logic [11:0] eb [4] = '{12'h002, 12'h004, 12'h006, 12'h008};
    logic [11:0] er [4] = '{12'h002, 12'h00C, 12'h01E, 12'h038};
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; op_a = ea[0]; op_b = eb[0]; in_rd = 3'd1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0: got %b want 1", in_ready); end
    @(posedge clk); #1;
    op_a = ea[1]; op_b = eb[1]; in_rd = 3'd2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    @(posedge clk); #1;
    op_a = ea[2]; op_b = eb[2]; in_rd = 3'd3;
    for (int s = 0; s < 4; s++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", s, in_ready); end
      total++; if (out_valid !== 1'b1 || result !== 12'h002 || out_rd !== 3'd1) begin
        bad++; $display("FAIL bp_stall_hold[%0d]: got v=%b r=%h rd=%0d want v=1 r=002 rd=1", s, out_valid, result, out_rd);
      end
      if (s < 3) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin op_a = ea[3]; op_b = eb[3]; in_rd = 3'd4; end
      if (k >= 2) in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || result !== er[k] || out_rd !== 3'(k + 1)) begin
        bad++; $display("FAIL bp_drain[%0d]: got v=%b r=%h rd=%0d want v=1 r=%h rd=%0d", k, out_valid, result, out_rd, er[k], k + 1);
      end
      @(posedge clk); #1;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    total++; if (retired !== 16'd4) begin bad++; $display("FAIL bp_retired: got %0d want 4", retired); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; op_a = 12'h003; op_b = 12'h005; in_rd = 3'd1;
    @(posedge clk); #1;
    op_a = 12'h002; op_b = 12'h002; in_rd = 3'd2;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    flush = 1'b1; op_a = 12'h009; op_b = 12'h009; in_rd = 3'd3;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL flush_retired: got %0d want 0", retired); end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL flush_retired_late: got %0d want 0", retired); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; op_a = 12'h003; op_b = 12'h005; in_rd = 3'd1;
    @(posedge clk); #1;
    op_a = 12'h002; op_b = 12'h003; in_rd = 3'd2;
    @(posedge clk); #1;
    op_a = 12'h004; op_b = 12'h004; in_rd = 3'd3;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || result !== 12'h006 || retired !== 16'd1) begin
      bad++; $display("FAIL areset_pre: got v=%b r=%h ret=%0d want v=1 r=006 ret=1", out_valid, result, retired);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    total++; if (result !== 12'h000) begin bad++; $display("FAIL areset_result: got %h want 000", result); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL areset_retired: got %0d want 0", retired); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL areset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_after: got %b want 0", out_valid); end
  endtask

`ifdef MUL_EX_ZERO_FLAG_EN
  task automatic test_zero_flag();
    do_reset();
    in_valid = 1'b1; op_a = 12'h010; op_b = 12'h010; in_rd = 3'd5;
    @(posedge clk); #1;
    op_a = 12'h003; op_b = 12'h005; in_rd = 3'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (result !== 12'h000 || res_zero !== 1'b1) begin
      bad++; $display("FAIL zero_set: got r=%h z=%b want r=000 z=1", result, res_zero);
    end
    @(posedge clk); #1;
    total++; if (result !== 12'h00F || res_zero !== 1'b0) begin
      bad++; $display("FAIL zero_clear: got r=%h z=%b want r=00F z=0", result, res_zero);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_op();
    test_signed_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef MUL_EX_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
